mul_iter_sequencer: RTL and testbench

//  Sequences the register file and combinational multiplier for iterative multiply: Rd = Rs^N * Rm.

---
 rtl/mul_iter_sequencer_if.sv | 24 ++
 rtl/mul_iter_sequencer.sv | 97 +++++++++
 tb/tb_mul_iter_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mul_iter_sequencer_if.sv
// mul_iter_sequencer_if: issue-side start/done handshake between decode logic and the sequencer
interface mul_iter_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int ITER_W = 6
) ();
  logic              start;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rm_addr;
  logic [ADDR_W-1:0] rn_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ITER_W-1:0] iter_count;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  modport master (
    output start, rs_addr, rm_addr, rn_addr, rd_addr, iter_count,
    input  busy, done, result
  );
  modport slave (
    input  start, rs_addr, rm_addr, rn_addr, rd_addr, iter_count,
    output busy, done, result
  );
endinterface

// File: rtl/mul_iter_sequencer.sv
// mul_iter_sequencer: drives reg file + multiplier to compute Rd = Rs^N * Rm (+ Rn when MUL_SEQ_ACC_EN is defined)
module mul_iter_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int ITER_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  mul_iter_sequencer_if.slave req,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [ADDR_W-1:0] rf_addr_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  output logic [DATA_W-1:0] mul_rs,
  output logic [DATA_W-1:0] mul_rm,
  input  logic [DATA_W-1:0] mul_result,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en
);
  typedef enum logic [2:0] {IDLE, READ, ITER, ADD, WRITE} state_t;
  state_t state, state_n, post;
  logic [ADDR_W-1:0] rd_q;
  logic [ITER_W-1:0] cnt;
  logic [DATA_W-1:0] op, acc, result_q;
  logic              done_q;
`ifdef MUL_SEQ_ACC_EN
  logic [ADDR_W-1:0] rn_q;
  assign post = ADD;
`else
  assign post = WRITE;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req.start ? READ : IDLE;
      READ:    state_n = (cnt != '0) ? ITER : post;
      ITER:    state_n = (cnt == ITER_W'(1)) ? post : ITER;
      ADD:     state_n = WRITE;
      WRITE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rf_addr_a <= '0;
      rf_addr_b <= '0;
      rd_q      <= '0;
      cnt       <= '0;
      op        <= '0;
      acc       <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
`ifdef MUL_SEQ_ACC_EN
      rn_q      <= '0;
`endif
    end else begin
      state  <= state_n;
      done_q <= (state == WRITE);
      case (state)
        IDLE: if (req.start) begin
          rf_addr_a <= req.rs_addr;
          rf_addr_b <= req.rm_addr;
          rd_q      <= req.rd_addr;
          cnt       <= req.iter_count;
`ifdef MUL_SEQ_ACC_EN
          rn_q      <= req.rn_addr;
`endif
        end
        READ: begin
          op  <= rf_data_a;
          acc <= rf_data_b;
`ifdef MUL_SEQ_ACC_EN
          // Point port A at Rn now so its data is ready during the single ADD cycle
          rf_addr_a <= rn_q;
`endif
        end
        ITER: begin
          acc <= mul_result;
          cnt <= cnt - 1'b1;
        end
        ADD:     acc <= acc + rf_data_a;
        WRITE:   result_q <= acc;
        default: ;
      endcase
    end
  end
  assign wr_en      = (state == WRITE);
  assign wr_addr    = wr_en ? rd_q : '0;
  assign wr_data    = wr_en ? acc : '0;
  assign mul_rs     = op;
  assign mul_rm     = acc;
  assign req.busy   = (state != IDLE);
  assign req.done   = done_q;
  assign req.result = result_q;
endmodule

// File: tb/tb_mul_iter_sequencer.sv
// tb_mul_iter_sequencer: randomized scoreboard bench with reg file / multiplier environment model
module tb_mul_iter_sequencer;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int IW = 6;
`ifdef MUL_SEQ_ACC_EN
  localparam int ACC = 1;
`else
  localparam int ACC = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mul_iter_sequencer_if #(.DATA_W(DW), .ADDR_W(AW), .ITER_W(IW)) req ();
  logic [AW-1:0] rf_addr_a, rf_addr_b, wr_addr;
  logic [DW-1:0] rf_data_a, rf_data_b, mul_rs, mul_rm, mul_result, wr_data;
  logic          wr_en;
  mul_iter_sequencer #(.DATA_W(DW), .ADDR_W(AW), .ITER_W(IW)) dut (
    .clk(clk), .rst(rst), .req(req),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .mul_rs(mul_rs), .mul_rm(mul_rm), .mul_result(mul_result),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
  );
  logic [DW-1:0] rf [16];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  always @(posedge clk) begin
    if (ld_en) rf[ld_addr] <= ld_data;
    if (wr_en) rf[wr_addr] <= wr_data;
  end
  assign rf_data_a  = rf[rf_addr_a];
  assign rf_data_b  = rf[rf_addr_b];
  assign mul_result = mul_rs * mul_rm;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] val;
    int            n;
    int            t;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req_v, $time);
    end
  endtask
  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (q.size() == 0) chk("spurious_wr", 1, 0);
        else begin
          chk("wr_addr", wr_addr, q[0].rd);
          chk("wr_data", wr_data, q[0].val);
          chk("busy_at_wr", req.busy, 1);
        end
      end
      if (req.done) begin
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          chk("result", req.result, q[0].val);
          chk("latency", cyc - q[0].t, q[0].n + 2 + ACC);
          chk("wr_before_done", prev_wr, 1);
          chk("busy_at_done", req.busy, 0);
          void'(q.pop_front());
        end
      end
    end
    prev_wr <= wr_en;
  end
  task automatic ld(input int a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = AW'(a); ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask
  task automatic issue(input int rs, input int rm, input int rn, input int rd, input int n, input bit push);
    int w = 0;
    logic [DW-1:0] a;
    exp_t e;
    while (req.busy && w < 500) begin @(negedge clk); w++; end
    if (w >= 500) chk("idle_timeout", 1, 0);
    a = rf[rm];
    for (int i = 0; i < n; i++) a = a * rf[rs];
    if (ACC != 0) a = a + rf[rn];
    req.start = 1'b1;
    req.rs_addr = AW'(rs); req.rm_addr = AW'(rm); req.rn_addr = AW'(rn);
    req.rd_addr = AW'(rd); req.iter_count = IW'(n);
    @(posedge clk);
    #1;
    e.rd = AW'(rd); e.val = a; e.n = n; e.t = cyc;
    if (push) q.push_back(e);
    @(negedge clk);
    req.start = 1'b0;
  endtask
  task automatic wait_done();
    int w = 0;
    while (!req.done && w < 200) begin
      chk("busy_during", req.busy, 1);
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("done_timeout", 0, 1);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_wr_en"}, wr_en, 0);
    chk({nm, "_done"}, req.done, 0);
    chk({nm, "_busy"}, req.busy, 0);
    chk({nm, "_result"}, req.result, 0);
    chk({nm, "_addr_a"}, rf_addr_a, 0);
    chk({nm, "_addr_b"}, rf_addr_b, 0);
    chk({nm, "_wr_addr"}, wr_addr, 0);
    chk({nm, "_wr_data"}, wr_data, 0);
    chk({nm, "_mul_rs"}, mul_rs, 0);
    chk({nm, "_mul_rm"}, mul_rm, 0);
  endtask
  initial begin
    req.start = 1'b0; req.rs_addr = '0; req.rm_addr = '0; req.rn_addr = '0;
    req.rd_addr = '0; req.iter_count = '0;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    ld(0, 32'd2); ld(1, 32'd1); ld(15, 32'd0);
    issue(0, 1, 15, 2, 30, 1'b1); wait_done();
    chk("t1_r2", rf[2], 32'h4000_0000);
    ld(1, 32'hDEAD_BEEF);
    issue(0, 1, 15, 3, 0, 1'b1); wait_done();
    chk("t2_r3", rf[3], 32'hDEAD_BEEF);
    ld(1, 32'd1);
    issue(0, 1, 15, 2, 33, 1'b1); wait_done();
    chk("t3_r2_wrap", rf[2], 32'h0);
    ld(2, 32'h1234_5678);
    issue(0, 1, 15, 2, 30, 1'b1);
    repeat (3) @(negedge clk);
    req.start = 1'b1; req.rs_addr = 4'd5; req.rm_addr = 4'd6; req.rd_addr = 4'd7; req.iter_count = 6'd1;
    repeat (5) @(negedge clk);
    req.start = 1'b0;
    wait_done();
    chk("t4_r2", rf[2], 32'h4000_0000);
    ld(9, 32'hCAFE_F00D);
    issue(0, 1, 15, 9, 20, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("t5_r9_kept", rf[9], 32'hCAFE_F00D);
    issue(0, 1, 15, 9, 3, 1'b1); wait_done();
    chk("t5_r9_after", rf[9], 32'd8);
`ifdef MUL_SEQ_ACC_EN
    ld(0, 32'd3); ld(1, 32'd1); ld(4, 32'd5);
    issue(0, 1, 4, 5, 2, 1'b1); wait_done();
    chk("t6_r5", rf[5], 32'h0000_000E);
`endif
    for (int k = 0; k < 40; k++) begin
      int nl = $urandom_range(0, 2);
      for (int j = 0; j < nl; j++) ld($urandom_range(0, 15), $urandom);
      issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 40), 1'b1);
      wait_done();
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
